// File: rtl/fc_lane_sched_fsm.sv
// Control FSM for a P-lane fully-connected layer: loads the input vector,
// then sweeps the output rows in groups of P lanes, sequencing the shared
// vector address, the per-lane weight ROM address, the accumulator controls
// and the serialised per-lane output handshake.
module fc_lane_sched_fsm #(
    parameter int unsigned M = 13,
    parameter int unsigned N = 16,
    parameter int unsigned P = 4,
    localparam int unsigned G  = (M + P - 1) / P,
    localparam int unsigned AX = (N > 1) ? $clog2(N) : 1,
    localparam int unsigned AW = (G * N > 1) ? $clog2(G * N) : 1,
    localparam int unsigned AS = (P > 1) ? $clog2(P) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          input_valid,
    output logic          input_ready,
    input  logic          output_ready,
    output logic          output_valid,
    output logic [AX-1:0] addr_x,
    output logic          wr_en_x,
    output logic [AW-1:0] addr_w,
    output logic          clear_acc,
    output logic          en_acc,
    output logic [AS-1:0] out_sel
);

    localparam int unsigned GW = (G > 1) ? $clog2(G) : 1;

    localparam logic [1:0] S_LOAD    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;
    localparam logic [1:0] S_OUTPUT  = 2'd3;

    localparam logic [AX-1:0] K_LAST = AX'(N - 1);
    localparam logic [GW-1:0] G_LAST = GW'(G - 1);
    localparam logic [AS-1:0] L_LAST = AS'(P - 1);
    localparam logic [AW-1:0] N_W    = AW'(N);

    logic [1:0]    r_state;
    logic [AX-1:0] r_k;
    logic [GW-1:0] r_g;
    logic [AS-1:0] r_lane;
    logic          r_en_pipe;

    logic [1:0]    w_state_nxt;
    logic [AX-1:0] w_k_nxt;
    logic [GW-1:0] w_g_nxt;
    logic [AS-1:0] w_lane_nxt;
    logic          w_accept;
    logic          w_last;
    logic [31:0]   w_row;
    logic [AX-1:0] w_k_eff;

    assign w_accept = input_valid && (r_state == S_LOAD);
    // Global row index of the lane being presented; the final group may be partial.
    assign w_row    = 32'(r_g) * P + 32'(r_lane);
    assign w_last   = (r_lane == L_LAST) || (w_row == M - 1);
    // Outside COMPUTE the address outputs hold the last column read.
    assign w_k_eff  = (r_state == S_COMPUTE) ? r_k : K_LAST;

    // Next-state and counter update logic.
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_g_nxt     = r_g;
        w_lane_nxt  = r_lane;
        case (r_state)
            S_LOAD: begin
                if (w_accept) begin
                    if (r_k == K_LAST) begin
                        w_k_nxt     = '0;
                        w_g_nxt     = '0;
                        w_state_nxt = S_COMPUTE;
                    end else begin
                        w_k_nxt = r_k + AX'(1);
                    end
                end
            end
            S_COMPUTE: begin
                if (r_k == K_LAST) begin
                    w_k_nxt     = '0;
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_k_nxt = r_k + AX'(1);
                end
            end
            S_DRAIN: begin
                w_lane_nxt  = '0;
                w_state_nxt = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (output_ready) begin
                    if (!w_last) begin
                        w_lane_nxt = r_lane + AS'(1);
                    end else if (r_g == G_LAST) begin
                        w_k_nxt     = '0;
                        w_g_nxt     = '0;
                        w_lane_nxt  = '0;
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_g_nxt     = r_g + GW'(1);
                        w_lane_nxt  = '0;
                        w_state_nxt = S_COMPUTE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
    end

    // State registers; en_acc trails COMPUTE by one cycle to match read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_LOAD;
            r_k       <= '0;
            r_g       <= '0;
            r_lane    <= '0;
            r_en_pipe <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_k       <= w_k_nxt;
            r_g       <= w_g_nxt;
            r_lane    <= w_lane_nxt;
            r_en_pipe <= (r_state == S_COMPUTE);
        end
    end

    // Output decode.
    always_comb begin
        input_ready  = (r_state == S_LOAD);
        wr_en_x      = input_valid && (r_state == S_LOAD) && !reset;
        addr_x       = (r_state == S_LOAD || r_state == S_COMPUTE) ? r_k : K_LAST;
        addr_w       = '0;
        if (r_state != S_LOAD) begin
            addr_w = AW'(r_g) * N_W + AW'(w_k_eff);
        end
        clear_acc    = (r_state == S_COMPUTE) && (r_k == '0);
        en_acc       = r_en_pipe;
        output_valid = (r_state == S_OUTPUT);
        out_sel      = r_lane;
    end

endmodule

// File: doc/fc_lane_sched_fsm.md
Name: fc_lane_sched_fsm

Overview:
Control FSM for a P-lane fully-connected (matrix-vector) layer. It loads an N-element input vector into the vector memory, then sweeps the M output rows in groups of P lanes. For each group it drives the shared vector address and the per-lane weight ROM address, sequences accumulator clear/enable, and serialises the P lane results onto one output handshake. It sits between the layer top level and the vector memory, the P weight ROMs (row g*P+lane stored in lane ROM at address g*N+k) and the P-lane datapath.

Parameters:
M, 13, number of output rows (matrix rows)
N, 16, input vector length (matrix columns)
P, 4, parallel lanes (rows computed per group)
G (localparam), ceil(M/P), number of row groups
AX (localparam), max(1,$clog2(N)), addr_x width
AW (localparam), max(1,$clog2(G*N)), addr_w width
AS (localparam), max(1,$clog2(P)), out_sel width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
input_valid  in  1  input beat offered
input_ready  out  1  controller accepts input beat
output_ready  in  1  consumer accepts output beat
output_valid  out  1  lane result on out_sel is valid
addr_x  out  AX  vector memory address (write in LOAD, read in COMPUTE)
wr_en_x  out  1  vector memory write enable
addr_w  out  AW  weight ROM address, common to all P lane ROMs
clear_acc  out  1  zero all P accumulators
en_acc  out  1  accumulate product into all P accumulators
out_sel  out  AS  lane selected onto output_data

Behaviour:
- Reset (async): state=LOAD, k=0, g=0, lane=0, acc-pipe=0. Outputs: addr_x=0, addr_w=0, wr_en_x=0, clear_acc=0, en_acc=0, output_valid=0, out_sel=0. input_ready=1 once in LOAD; the bench does not sample it while reset is high.
- States: LOAD, COMPUTE, DRAIN, OUTPUT.
- LOAD:
  - input_ready=1. wr_en_x = input_valid (combinational). addr_x = k.
  - On each accept (input_valid & input_ready): k++. On accept with k==N-1: k=0, g=0, go to COMPUTE.
  - A cycle without input_valid holds k.
- COMPUTE (exactly N cycles):
  - Cycle k drives addr_x=k and addr_w=g*N+k.
  - clear_acc=1 only in cycle k=0.
  - Memory and ROM read latency is 1. en_acc is a 1-cycle delayed copy of the COMPUTE-valid flag, so en_acc is high in COMPUTE cycles 1..N-1 and in DRAIN. That gives exactly N en_acc cycles per group.
  - clear_acc and en_acc are never high in the same cycle.
  - After k==N-1: k=0, go to DRAIN.
- DRAIN (1 cycle): en_acc=1, addr outputs hold their last value. Next state OUTPUT with lane=0.
- OUTPUT:
  - output_valid=1, out_sel=lane. Both are held stable until output_ready.
  - On handshake, last = (lane==P-1) or (g*P+lane==M-1).
    - If not last: lane++.
    - If last and g<G-1: g++, lane=0, go to COMPUTE.
    - If last and g==G-1: go to LOAD with k=0.
  - Rows at or beyond M in the final group are never presented.
- input_ready=0 in COMPUTE, DRAIN and OUTPUT; there is no overlap of load and compute.
- Latency, full vector to first output_valid: N (COMPUTE) + 1 (DRAIN) cycles after the N-th accept cycle.
- Addresses stay within range: addr_x<N and addr_w<G*N always. No wrap-around beyond these bounds.
- Reset asserted mid-operation: all state is abandoned, accumulators are not cleared by this block, and the next group begins with clear_acc.

Test Plan:
1. Defaults; reset, then 16 back-to-back input_valid beats -> wr_en_x high 16 cycles with addr_x 0..15; input_ready low the cycle after the 16th accept; COMPUTE starts with clear_acc=1 and addr_w=0.
2. Group 0 compute -> addr_w 0..15 over 16 cycles; en_acc high 16 consecutive cycles starting one cycle after clear_acc; output_valid rises 17 cycles after the first COMPUTE cycle.
3. Full run with output_ready=1 -> 13 output beats total: out_sel 0,1,2,3 for groups 0-2, then a single beat out_sel=0 for group 3 (row 12, addr_w 48..63); returns to LOAD with input_ready=1.
4. output_ready held low 5 cycles at group 1, lane 2 -> output_valid stays 1, out_sel stays 2; lane advances only on the handshake cycle.
5. input_valid pattern 1,0,0,1,... -> addr_x advances only on accept cycles; wr_en_x=0 on bubble cycles; exactly 16 writes before COMPUTE.
6. reset pulsed during COMPUTE of group 2 (k=7) -> all outputs 0 at once, state LOAD; the following full vector run reproduces scenario 3. Repeat with P=1: 13 groups, each group gives one beat with out_sel=0.
